// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and arbitration mode.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbState_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arbMode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Winner selection: fixed priority from port 0, or round-robin starting after the last winner.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     lastIdx,
    input  arbMode_t             mode,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grantIdx,
    output logic                 grantValid
);

    int               pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant      = '0;
        grantIdx   = '0;
        grantValid = 1'b0;
        pos        = 0;
        cand       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // lastIdx + 1 + k never reaches 2*NUM_PORTS, so one subtraction wraps it
            if (mode == ARB_RR) begin
                pos = int'(lastIdx) + 1 + k;
                if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            end else begin
                pos = k;
            end
            cand = IDX_W'(pos);
            if (!grantValid && req[cand]) begin
                grantValid  = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between NUM_PORTS requesters with
// waitrequest handshakes, optional wait states and fixed or round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int       NUM_PORTS   = 2,
    parameter int       ADDR_W      = 12,
    parameter int       DATA_W      = 16,
    parameter int       WAIT_STATES = 0,
    parameter arbMode_t ARB_MODE    = ARB_RR
) (
    input  logic                              Clock,
    input  logic                              ResetN,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  PortAddr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  PortWData,
    input  logic [NUM_PORTS-1:0]              PortRead,
    input  logic [NUM_PORTS-1:0]              PortWrite,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]  PortRData,
    output logic [NUM_PORTS-1:0]              PortWaitreq,
    output logic [ADDR_W-1:0]                 MemAddr,
    output logic [DATA_W-1:0]                 MemWData,
    output logic                              MemWrite,
    input  logic [DATA_W-1:0]                 MemRData
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arbState_t                          state;
    logic [IDX_W-1:0]                   winner, rrPtr, grantIdx;
    logic [NUM_PORTS-1:0]               req, grant;
    logic                               grantValid;
    logic [ADDR_W-1:0]                  latAddr, selAddr;
    logic [DATA_W-1:0]                  latWData, selWData;
    logic                               latWrite, selWrite;
    logic [3:0]                         waitCnt;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rdataReg;

    assign req = PortRead | PortWrite;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) uArb (
        .req        (req),
        .lastIdx    (rrPtr),
        .mode       (ARB_MODE),
        .grant      (grant),
        .grantIdx   (grantIdx),
        .grantValid (grantValid)
    );

    always_comb begin
        selAddr  = '0;
        selWData = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                selAddr  = selAddr  | PortAddr[i];
                selWData = selWData | PortWData[i];
            end
        end
        selWrite = |(grant & PortWrite);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            winner   <= '0;
            rrPtr    <= IDX_W'(NUM_PORTS - 1);
            latAddr  <= '0;
            latWData <= '0;
            latWrite <= 1'b0;
            waitCnt  <= '0;
            rdataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        winner   <= grantIdx;
                        rrPtr    <= grantIdx;
                        latAddr  <= selAddr;
                        latWData <= selWData;
                        latWrite <= selWrite;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    waitCnt <= 4'(WAIT_STATES);
                    state   <= (WAIT_STATES == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    // A requester that dropped mid-access gets no data delivered
                    if (!latWrite && req[winner]) rdataReg[winner] <= MemRData;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MemAddr  = latAddr;
    assign MemWData = latWData;
    assign MemWrite = (state == ISSUE) && latWrite;

    // Read data is forwarded in the completing cycle so it is valid together with waitreq low
    always_comb begin
        PortWaitreq = '0;
        PortRData   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            PortWaitreq[i] = req[i] & ~((state == RESP) && (winner == IDX_W'(i)));
            PortRData[i]   = ((state == RESP) && (winner == IDX_W'(i)) && !latWrite && req[i])
                             ? MemRData : rdataReg[i];
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester ports (port 0 = instruction, port 1 = data in the processor top).
REQ-002 Parameter ADDR_W, default 12, memory word-address width.
REQ-003 Parameter DATA_W, default 16, data width.
REQ-004 Parameter WAIT_STATES, default 0, extra cycles inserted per access (0..15).
REQ-005 Parameter ARB_MODE, default ARB_RR, arbitration mode: ARB_FIXED or ARB_RR.
REQ-006 Clock  in  1  single clock; all state changes on its rising edge.
REQ-007 ResetN  in  1  asynchronous, active-low reset.
REQ-008 PortAddr  in  NUM_PORTS x ADDR_W  per-port word address.
REQ-009 PortWData  in  NUM_PORTS x DATA_W  per-port write data.
REQ-010 PortRead  in  NUM_PORTS  per-port read request.
REQ-011 PortWrite  in  NUM_PORTS  per-port write request.
REQ-012 PortRData  out  NUM_PORTS x DATA_W  per-port read data.
REQ-013 PortWaitreq  out  NUM_PORTS  per-port stall; high = request not yet completed.
REQ-014 MemAddr  out  ADDR_W  address to single-port synchronous RAM (1-cycle read latency).
REQ-015 MemWData  out  DATA_W  write data to RAM.
REQ-016 MemWrite  out  1  RAM write enable.
REQ-017 MemRData  in  DATA_W  RAM read data, valid one cycle after address.

Function
REQ-018 Request on port i: Req[i] = PortRead[i] | PortWrite[i]; both high means write.
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: any Req -> select winner, latch index, address, data, op; next ISSUE; else stay.
REQ-021 ISSUE: MemAddr/MemWData from latch; MemWrite high this cycle only for writes; wait counter loaded with WAIT_STATES; next RESP if WAIT_STATES==0, else WAIT.
REQ-022 WAIT: counter decrements each cycle; at counter==1 next RESP.
REQ-023 RESP: PortWaitreq[winner] low; PortRData[winner] loaded with MemRData (reads only), held until the port's next read completes; next IDLE.
REQ-024 Latency: request sampled in IDLE at cycle 0 completes (waitreq low) in cycle 2+WAIT_STATES.
REQ-025 PortWaitreq[i] = Req[i] & ~(state==RESP & winner==i), combinational.
REQ-026 Requester holds address/data/op stable while waitreq high; a request dropped mid-access still completes on RAM, with no response delivered.
REQ-027 ARB_FIXED: lowest-index requesting port wins.
REQ-028 ARB_RR: search begins at last winner+1, wrapping NUM_PORTS-1 -> 0; pointer updates only on grant.
REQ-029 Non-winning requesters stay stalled; no request is lost or reordered within a port.
REQ-030 MemAddr/MemWData hold last latched values outside ISSUE; MemWrite low outside ISSUE.

Reset
REQ-031 ResetN low forces immediately: state IDLE, MemWrite 0, MemAddr 0, MemWData 0, all PortRData 0, counter 0, RR pointer NUM_PORTS-1 (port 0 first).
REQ-032 Reset mid-access aborts it; no completion is signalled; first grant after release follows REQ-031 pointer.
REQ-033 PortWaitreq during reset equals Req (stall any requester).

Structure
REQ-034 Package mem_arb_pkg holds the state enum, ARB_FIXED/ARB_RR constants and the arb-mode type.
REQ-035 Sub-module rr_arbiter (request vector, pointer, mode -> one-hot grant + index) performs winner selection.

Verification
REQ-036 WAIT_STATES=0, port1 write 0x00A=0x1234 then read 0x00A -> MemWrite one cycle, read completes cycle 2, PortRData[1]=0x1234.
REQ-037 WAIT_STATES=3, single read -> PortWaitreq high cycles 0-4, low in cycle 5.
REQ-038 ARB_RR, both ports request continuously -> grants alternate 0,1,0,1; each port completes every 6 cycles (WAIT_STATES=0).
REQ-039 ARB_FIXED, both ports request continuously -> port 0 always wins; port 1 stays stalled.
REQ-040 ResetN pulsed low during WAIT -> MemWrite 0 immediately, state IDLE, no waitreq-low pulse, next grant to port 0.
REQ-041 Replace processor-top memory wiring with NUM_PORTS=2 unified RAM -> processor program runs to same final memory contents as with separate memories.
